updown_counter: RTL and testbench

- Parameterised up/down binary counter with synchronous load, selectable wrap or saturate behaviour, and a boundary flag.
- Companion to the existing 4-bit up counter: adds the down direction and preset capability.
- Used as a general countdown/timer and position counter.
- Single clock domain; synchronous active-high reset.

---
 rtl/updown_counter.sv | 52 +++++
 tb/tb_updown_counter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Up/down binary counter with synchronous load, wrap-or-saturate boundary
// handling, a registered terminal-count pulse and zero/max decodes.
module updown_counter #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero,
  output logic             max
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic             boundary;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_nxt;

  assign zero = (out == '0);
  assign max  = (out == MAX_VAL);

  // Modulo-2^WIDTH step already yields the wrap target (0 or MAX).
  always_comb begin
    boundary  = up_down ? max : zero;
    step      = up_down ? out + 1'b1 : out - 1'b1;
    count_nxt = step;
    if (boundary && sat_mode) count_nxt = out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= RESET_VAL;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_val;
      tc  <= 1'b0;
    end else if (enable) begin
      out <= count_nxt;
      tc  <= boundary;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: stimulus queues expected out/tc per edge, a negedge
// monitor pops and compares out, tc, zero and max for two configurations.
module tb_updown_counter;

  typedef struct {
    logic [7:0] o;
    logic       tc;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4, RESET_VAL=0
  logic       reset = 1'b1, enable = 1'b0, up_down = 1'b1, load = 1'b0, sat_mode = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] out;
  logic       tc, zero, max;

  // WIDTH=8, RESET_VAL=200
  logic       reset8 = 1'b1, enable8 = 1'b0;
  logic [7:0] out8;
  logic       tc8, zero8, max8;

  updown_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .out(out), .tc(tc), .zero(zero), .max(max)
  );

  updown_counter #(.WIDTH(8), .RESET_VAL(8'd200)) dut8 (
    .clk(clk), .reset(reset8), .enable(enable8), .up_down(1'b1), .load(1'b0),
    .load_val(8'd0), .sat_mode(1'b0), .out(out8), .tc(tc8), .zero(zero8), .max(max8)
  );

  exp_t q4[$];
  exp_t q8[$];
  int   checks = 0;
  int   failures = 0;

  task automatic cyc(input logic r, input logic ld, input logic [3:0] lv, input logic en,
                     input logic ud, input logic sm, input int eo, input logic etc,
                     input string tag);
    exp_t e;
    reset = r; load = ld; load_val = lv; enable = en; up_down = ud; sat_mode = sm;
    @(posedge clk);
    #1;
    e.o = 8'(eo); e.tc = etc; e.tag = tag;
    q4.push_back(e);
  endtask

  task automatic cyc8(input logic r, input logic en, input int eo, input logic etc,
                      input string tag);
    exp_t e;
    reset8 = r; enable8 = en;
    @(posedge clk);
    #1;
    e.o = 8'(eo); e.tc = etc; e.tag = tag;
    q8.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks += 4;
      if (out !== e.o[3:0]) begin failures++; $display("FAIL %s out got=%0d exp=%0d", e.tag, out, e.o[3:0]); end
      if (tc !== e.tc) begin failures++; $display("FAIL %s tc got=%0b exp=%0b (out=%0d)", e.tag, tc, e.tc, out); end
      if (zero !== (e.o[3:0] == 4'd0)) begin failures++; $display("FAIL %s zero got=%0b exp_out=%0d", e.tag, zero, e.o[3:0]); end
      if (max !== (e.o[3:0] == 4'd15)) begin failures++; $display("FAIL %s max got=%0b exp_out=%0d", e.tag, max, e.o[3:0]); end
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      checks += 4;
      if (out8 !== e.o) begin failures++; $display("FAIL %s out8 got=%0d exp=%0d", e.tag, out8, e.o); end
      if (tc8 !== e.tc) begin failures++; $display("FAIL %s tc8 got=%0b exp=%0b (out8=%0d)", e.tag, tc8, e.tc, out8); end
      if (zero8 !== (e.o == 8'd0)) begin failures++; $display("FAIL %s zero8 got=%0b exp_out=%0d", e.tag, zero8, e.o); end
      if (max8 !== (e.o == 8'd255)) begin failures++; $display("FAIL %s max8 got=%0b exp_out=%0d", e.tag, max8, e.o); end
    end
  end

  initial begin
    // 1: reset (unknown controls while in reset), then up-count with wrap
    cyc(1, 1'bx, 4'hx, 1'bx, 1'bx, 1'bx, 0, 0, "rst_x");
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "rst");
    for (int k = 1; k <= 18; k++) cyc(0, 0, 0, 1, 1, 0, k % 16, k == 16, "up_wrap");

    // 2: load 2 then down-count through zero
    cyc(0, 1, 4'd2, 0, 0, 0, 2, 0, "load2");
    cyc(0, 0, 0, 1, 0, 0, 1, 0, "dn");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, "dn");
    cyc(0, 0, 0, 1, 0, 0, 15, 1, "dn_wrap");
    cyc(0, 0, 0, 1, 0, 0, 14, 0, "dn");

    // 3: saturate at MAX, then reverse
    cyc(0, 1, 4'd14, 1, 1, 1, 14, 0, "load14");
    cyc(0, 0, 0, 1, 1, 1, 15, 0, "sat_up");
    cyc(0, 0, 0, 1, 1, 1, 15, 1, "sat_hold");
    cyc(0, 0, 0, 1, 1, 1, 15, 1, "sat_hold");
    cyc(0, 0, 0, 1, 0, 1, 14, 0, "sat_rev");

    // saturate at zero, then hold clears tc
    cyc(0, 1, 4'd1, 0, 0, 1, 1, 0, "load1");
    cyc(0, 0, 0, 1, 0, 1, 0, 0, "sat_dn");
    cyc(0, 0, 0, 1, 0, 1, 0, 1, "sat_zero");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, "hold_tc_clr");

    // 4: priority reset > load > enable
    cyc(0, 1, 4'd6, 0, 1, 0, 6, 0, "load6");
    cyc(1, 1, 4'd9, 1, 1, 0, 0, 0, "prio_rst");
    cyc(0, 1, 4'd9, 1, 1, 0, 9, 0, "prio_load");
    cyc(0, 0, 4'd9, 0, 1, 0, 9, 0, "hold");
    cyc(0, 0, 4'd9, 0, 1, 0, 9, 0, "hold");

    // 5: reset mid-count
    cyc(0, 1, 4'd5, 0, 1, 0, 5, 0, "load5");
    cyc(0, 0, 0, 1, 1, 0, 6, 0, "up");
    cyc(0, 0, 0, 1, 1, 0, 7, 0, "up");
    cyc(1, 0, 0, 1, 1, 0, 0, 0, "rst_mid");
    cyc(0, 0, 0, 1, 1, 0, 1, 0, "resume");
    cyc(0, 0, 0, 1, 1, 0, 2, 0, "resume");

    // 6: direction toggle every clock
    cyc(0, 1, 4'd5, 0, 1, 0, 5, 0, "load5");
    cyc(0, 0, 0, 1, 1, 0, 6, 0, "tog");
    cyc(0, 0, 0, 1, 0, 0, 5, 0, "tog");
    cyc(0, 0, 0, 1, 1, 0, 6, 0, "tog");
    cyc(0, 0, 0, 1, 0, 0, 5, 0, "tog");

    // 6b: WIDTH=8, RESET_VAL=200, 60 up steps -> single tc at 255->0, ends at 4
    cyc8(1, 0, 200, 0, "w8_rst");
    for (int k = 1; k <= 60; k++) cyc8(0, 1, (200 + k) % 256, k == 56, "w8_up");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q4.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL drain q4=%0d q8=%0d exp=0", q4.size(), q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
